uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the uart transmit side
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT} arb_state_t;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts after last_grant
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int          start;
  int          pos;
  logic [N-1:0] rot;

  // Rotate so the requester after last_grant sits at bit 0, pick lowest, rotate back.
  always_comb begin
    start = (int'(last_grant) + 1) % N;
    rot   = N'({req, req} >> start);
    pos   = 0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = k;
        any = 1'b1;
      end
    end
    grant_idx = IW'((pos + start) % N);
    grant     = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart transmitter with frame locking
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_din,
  output logic                          tx_start,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = idx_width(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t          state, state_nxt;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [GW-1:0]       arb_idx;
  logic                arb_any;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       accept_idx;
  logic                accept;
  logic                last_q;
  logic                lock_ok;
  logic [BW-1:0]       burst_cnt;

  rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  assign tx_start = (state == START);

  // The owner keeps the transmitter only while its frame is open, under budget and still feeding.
  assign lock_ok = !last_q && (int'(burst_cnt) + 1 < MAX_BURST) && req_valid[grant_id];

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    accept     = 1'b0;
    accept_idx = arb_idx;
    case (state)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (lock_ok) begin
            req_ready[grant_id] = 1'b1;
            accept     = 1'b1;
            accept_idx = grant_id;
            state_nxt  = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_din     <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      last_q     <= 1'b0;
      burst_cnt  <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_din   <= req_data[accept_idx*DATA_WIDTH +: DATA_WIDTH];
        grant_id <= accept_idx;
        last_q   <= req_last[accept_idx];
        busy     <= 1'b1;
      end
      if (state == WAIT && tx_done) begin
        if (state_nxt == IDLE) begin
          last_grant <= grant_id;
          burst_cnt  <= '0;
          busy       <= 1'b0;
        end else if (int'(burst_cnt) < MAX_BURST) begin
          burst_cnt <= burst_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   tx_din;
  logic            tx_start;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            busy;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_din    (tx_din),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [7:0]  data;
    int          gap;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [8:0] rq[N][$];
  int         total = 0;
  int         passed = 0;
  int         cyc = 0;
  int         acc_cyc = -100;
  int         done_cyc = -100;
  logic       abort;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
  endtask

  task automatic expect_tx(input int id, input logic [7:0] d, input int gap);
    exp_t x;
    x.id = id; x.data = d; x.gap = gap;
    sb.push_back(x);
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && rq_empty() && !busy) break;
    end
    chk({name, "_drain"}, int'(k < 400), 1);
  endtask

  // Requester model: consume accepted bytes after the edge, present queue heads.
  initial begin
    logic [N-1:0] hs;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      hs = rst ? '0 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = rq[i][0][7:0];
          req_last[i]           = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: done tick a fixed time after each start, abandoned on reset.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          if (rst) abort = 1'b1;
        end
        if (!abort) begin
          #1 tx_done = 1'b1;
          @(posedge clk);
          #1 tx_done = 1'b0;
        end
      end
    end
  end

  // Monitor: every tx_start is matched against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (req_ready != '0) begin
        chk("ready_onehot", int'($onehot(req_ready)), 1);
        acc_cyc = cyc;
      end
      if (tx_done) done_cyc = cyc;
      if (tx_start) begin
        chk("tx_start_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("tx_din", int'(tx_din), int'(e.data));
          chk("grant_id", int'(grant_id), e.id);
          chk("accept_to_start", cyc - acc_cyc, 1);
          if (e.gap != 0) chk("done_to_start", cyc - done_cyc, e.gap);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_tx_din", int'(tx_din), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Round robin across 0,1,3 from the reset pointer.
    send(0, 8'h01, 1); send(1, 8'h11, 1); send(3, 8'h31, 1);
    send(0, 8'h02, 1); send(1, 8'h12, 1); send(3, 8'h32, 1);
    expect_tx(0, 8'h01, 0); expect_tx(1, 8'h11, 2); expect_tx(3, 8'h31, 2);
    expect_tx(0, 8'h02, 2); expect_tx(1, 8'h12, 2); expect_tx(3, 8'h32, 2);
    drain("rr");

    // Single byte from requester 2.
    send(2, 8'hA5, 1);
    expect_tx(2, 8'hA5, 0);
    drain("single");
    chk("single_grant_id", int'(grant_id), 2);
    chk("single_busy", int'(busy), 0);

    // Locked three-byte frame, then the waiting requester.
    send(1, 8'h10, 0); send(1, 8'h11, 0); send(1, 8'h12, 1);
    expect_tx(1, 8'h10, 0); expect_tx(1, 8'h11, 1); expect_tx(1, 8'h12, 1);
    expect_tx(0, 8'h20, 2);
    repeat (4) @(posedge clk);
    send(0, 8'h20, 1);
    drain("frame");

    // Burst limit forces rotation every MB bytes.
    for (int i = 0; i < 10; i++) send(0, 8'(8'h50 + i), 0);
    expect_tx(0, 8'h50, 0); expect_tx(0, 8'h51, 1); expect_tx(0, 8'h52, 1); expect_tx(0, 8'h53, 1);
    expect_tx(2, 8'h2A, 2);
    expect_tx(0, 8'h54, 2); expect_tx(0, 8'h55, 1); expect_tx(0, 8'h56, 1); expect_tx(0, 8'h57, 1);
    expect_tx(0, 8'h58, 2); expect_tx(0, 8'h59, 1);
    repeat (4) @(posedge clk);
    send(2, 8'h2A, 1);
    drain("burst");

    // Reset while waiting on the transmitter.
    send(1, 8'h3C, 1);
    expect_tx(1, 8'h3C, 0);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        if (tx_start) break;
      end
      chk("rst_wait_start", int'(k < 50), 1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", int'(req_ready), 0);
    chk("midrst_tx_din", int'(tx_din), 0);
    chk("midrst_tx_start", int'(tx_start), 0);
    chk("midrst_grant_id", int'(grant_id), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    send(0, 8'h40, 1); send(1, 8'h41, 1);
    expect_tx(0, 8'h40, 0); expect_tx(1, 8'h41, 2);
    drain("post_rst");

    // Spurious done with nothing pending.
    @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("spurious_busy", int'(busy), 0);
      chk("spurious_start", int'(tx_start), 0);
      chk("spurious_ready", int'(req_ready), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
